// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared constants and types for the I/O UART transmitter
//
// Purpose: register word offsets, STATUS/CTRL bit positions and the shifter
// state encoding shared by io_uart_tx and its testbench.
// Ports: none (package).
package io_uart_pkg;

  // Register word offsets, selected by addr[2:1]
  localparam logic [1:0] WORD_DATA   = 2'd0;
  localparam logic [1:0] WORD_STATUS = 2'd1;
  localparam logic [1:0] WORD_DIV    = 2'd2;
  localparam logic [1:0] WORD_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/io_uart_tx_fifo.sv
// rtl/io_uart_tx_fifo.sv - byte-wide synchronous FIFO feeding the UART shifter
//
// Purpose: small circular buffer; the caller only asserts push_i when the
// byte can be accepted (not full, or a pop in the same cycle) and pop_i when
// not empty. dout_o shows the head entry combinationally.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset (empties the FIFO)
//   push_i   write din_i at the tail
//   pop_i    advance the head
//   din_i    byte to push
//   dout_o   byte at the head
//   full_o   DEPTH entries held
//   empty_o  no entries held
import io_uart_pkg::*;

module io_uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; a push while full with a simultaneous pop
  // overwrites the slot being read, which is safe since dout_o is read first.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped UART transmitter with TX FIFO and level irq
//
// Purpose: decodes an 8-byte register window (DATA, STATUS, DIV, CTRL),
// queues bytes in a FIFO and serialises them 8N1, LSB first, on tx.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   dread_addr   read byte address
//   dread_data   registered read data, valid the cycle after dread_addr
//   dwrite_addr  write byte address
//   dwrite_data  write data
//   dwrite_en    byte-lane enables ([0] low, [1] high), pre-gated to I/O space
//   tx           serial output, idle high
//   interrupt    level irq: irq_en && FIFO empty && shifter idle
import io_uart_pkg::*;

module io_uart_tx #(
  parameter logic [15:0] BASEADDR    = 16'h0010,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  output logic        tx,
  output logic        interrupt
);

  // Address decode
  logic       wr_hit, rd_hit;
  logic [1:0] wr_word, rd_word;

  assign wr_hit  = (dwrite_addr[15:3] == BASEADDR[15:3]);
  assign wr_word = dwrite_addr[2:1];
  assign rd_hit  = (dread_addr[15:3] == BASEADDR[15:3]);
  assign rd_word = dread_addr[2:1];

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{dread_addr[0], dwrite_addr[0]};

  // Register file
  logic [15:0] div_q, div_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        irq_q;

  // Shifter
  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;

  // FIFO interface
  logic       push_req, push_ok, pop;
  logic [7:0] fifo_dout;
  logic       fifo_full, fifo_empty;

  assign push_req = wr_hit && (wr_word == WORD_DATA) && dwrite_en[0];
  // A full FIFO still accepts when the shifter frees a slot this cycle.
  assign push_ok  = push_req && (!fifo_full || pop);

  io_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_ok),
    .pop_i   (pop),
    .din_i   (dwrite_data[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Register writes
  always_comb begin
    div_d    = div_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (wr_hit && (wr_word == WORD_DIV)) begin
      if (dwrite_en[0]) div_d[7:0]  = dwrite_data[7:0];
      if (dwrite_en[1]) div_d[15:8] = dwrite_data[15:8];
    end
    if (wr_hit && (wr_word == WORD_CTRL) && dwrite_en[0]) begin
      en_d     = dwrite_data[CTRL_EN];
      irq_en_d = dwrite_data[CTRL_IRQEN];
    end
    if (wr_hit && (wr_word == WORD_STATUS) && dwrite_en[0] && dwrite_data[STAT_OVF])
      ovf_d = 1'b0;
    if (push_req && !push_ok)
      ovf_d = 1'b1;
  end

  // Read mux
  always_comb begin
    rd_data_d = 16'h0000;
    if (rd_hit) begin
      case (rd_word)
        WORD_STATUS: begin
          rd_data_d[STAT_FULL]  = fifo_full;
          rd_data_d[STAT_EMPTY] = fifo_empty;
          rd_data_d[STAT_BUSY]  = (state_q != IDLE);
          rd_data_d[STAT_OVF]   = ovf_q;
        end
        WORD_DIV: rd_data_d = div_q;
        WORD_CTRL: begin
          rd_data_d[CTRL_EN]    = en_q;
          rd_data_d[CTRL_IRQEN] = irq_en_q;
        end
        default: rd_data_d = 16'h0000;
      endcase
    end
  end

  // Shifter next state; every bit period is a countdown from DIV to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q && !fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          cnt_d   = div_q;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_q;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_q;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next frame when more data is waiting.
          if (en_q && !fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            cnt_d   = div_q;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx follows the state being entered so it changes on the same edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= DEFAULT_DIV;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= 16'h0000;
      irq_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      div_q     <= div_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_en_q && fifo_empty && (state_q == IDLE);
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  assign dread_data = rd_data_q;
  assign tx         = tx_q;
  assign interrupt  = irq_q;

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
Memory-mapped UART transmitter on the data bus, on the I/O side of the RAM/IO address split (addresses below RAMADDRBASE). Consumes dwrite_* cycles gated by the I/O write-enable decode. Returns registered read data to the I/O read-data mux. Serialises bytes from a small FIFO onto a tx line and drives a level interrupt toward the CPU.

Parameters:
BASEADDR, 16'h0010, byte address of register window; 8-byte aligned; must lie below RAMADDRBASE
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16
DEFAULT_DIV, 16'd3, reset value of DIV; bit time = DIV+1 clk cycles

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
dread_addr  input  16  read byte address
dread_data  output  16  read data, valid the cycle after dread_addr
dwrite_addr  input  16  write byte address
dwrite_data  input  16  write data
dwrite_en  input  2  byte-lane enables: [0]=low byte, [1]=high byte; already gated to I/O space
tx  output  1  serial output, idle high
interrupt  output  1  level interrupt request

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Decode: hit when addr[15:3]==BASEADDR[15:3]. Word select is addr[2:1]; addr[0] is ignored.
- Register words:
  - 0 DATA: write with dwrite_en[0] pushes dwrite_data[7:0]. Reads as 0.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (shifter not IDLE), bit3 overflow (sticky), other bits 0. A write with dwrite_en[0] and dwrite_data[3]=1 clears overflow.
  - 2 DIV: R/W; lanes written independently per dwrite_en.
  - 3 CTRL: bit0 enable, bit1 irq_en. Other bits read 0.
- Read path: dread_data is registered from dread_addr sampled at the previous edge. A miss returns 16'h0000. Reads have no side effects.
- Reset values: tx=1, interrupt=0, dread_data=0, FIFO empty, overflow=0, DIV=DEFAULT_DIV, CTRL=0, shifter IDLE.
- FIFO push/pop:
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Shifter FSM: IDLE, START, DATA, STOP.
  - IDLE: if enable && !empty, pop the FIFO head into the shift register, go to START, load the bit counter with DIV.
  - Each bit lasts DIV+1 cycles; the counter counts down to 0.
  - tx is registered: 0 in START; shreg[0] in DATA, 8 bits LSB-first with bit index 0..7; 1 in STOP and IDLE.
  - End of STOP: if enable && !empty, pop and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing: a write sampled at edge E makes the FIFO non-empty after E. The shifter loads at E+1, and tx falls after E+1. Frame length is 10*(DIV+1) cycles.
- Enable cleared mid-frame: the current frame completes; no further loads occur.
- DIV written mid-frame: takes effect at the next bit-counter reload.
- interrupt is registered: irq_en && empty && state==IDLE.
- Reset mid-frame: tx returns to 1 immediately (asynchronously) and the FIFO contents are discarded.

Decomposition:
- Package io_uart_pkg holds:
  - word offsets DATA/STATUS/DIV/CTRL
  - STATUS bit positions (FULL, EMPTY, BUSY, OVF)
  - CTRL bit positions (EN, IRQEN)
  - enum tx_state_t {IDLE, START, DATA, STOP}
- Sub-module io_uart_tx_fifo: synchronous FIFO with push, pop, din, dout, full, empty, parameterised by depth. The top level holds the register file, read mux and shifter FSM.

Test Plan:
1. Reset, then read STATUS, DIV and CTRL -> 16'h0002, 16'h0003, 16'h0000; tx=1; interrupt=0.
2. CTRL=1, DIV=3, write DATA=8'h55 at edge E -> tx low for cycles E+1..E+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high for 4 cycles; total 40 cycles; STATUS.busy=1 during the frame.
3. CTRL=0, write five bytes -> first four accepted (STATUS full=1), fifth sets overflow (STATUS=16'h0009). Writing STATUS with bit3=1 then reads 16'h0001.
4. With 2 bytes queued, set CTRL=1 -> two frames back-to-back with no idle gap between the first stop bit and the second start bit; FIFO empty after the second load.
5. CTRL=3, send one byte -> interrupt=0 while busy and 1 one cycle after the shifter returns to IDLE; writing CTRL=1 drops interrupt.
6. Assert reset mid-DATA bit -> tx=1 immediately; STATUS after release reads 16'h0002; no residual frame is sent.
